// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// default timeout and the byte-lane helpers used on the request path.
package mem_lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_lsu_load_ext.sv
// Combinational load-data alignment and sign/zero extension; kept standalone so the
// same block can sit in WB if the load path moves there.
module mem_lsu_load_ext
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LBU:     o_result = {24'd0, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LHU:     o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues handshaked DRAM requests, stalls the pipe while
// an access is outstanding, and produces the MEM-stage writeback value.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_mem_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_mem_i,
    input  logic [31:0] addr_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] wd_mem_i,
    output logic [31:0] wd_mem_o,
    output logic        lsu_stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dram_req_o,
    output logic        dram_we_o,
    output logic [31:0] dram_addr_o,
    output logic [3:0]  dram_be_o,
    output logic [31:0] dram_wdata_o,
    input  logic        dram_gnt_i,
    input  logic        dram_rvalid_i,
    input  logic [31:0] dram_rdata_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state, w_next;
    logic [15:0] r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;

    logic        w_access, w_legal, w_mis, w_bad, w_go, w_tmo;
    logic [31:0] w_ext;

    // Gating with rst_n keeps the request outputs quiet while reset is held
    assign w_access = rst_n && instr_valid_mem_i && (mem_re_i || mem_we_i);
    assign w_legal  = mem_we_i ? (funct3_mem_i inside {SB, SH, SW})
                               : (funct3_mem_i inside {LB, LH, LW, LBU, LHU});
    assign w_mis    = (funct3_mem_i[1:0] == 2'b01 && addr_mem_i[0]) ||
                      (funct3_mem_i[1:0] == 2'b10 && addr_mem_i[1:0] != 2'b00);
    assign w_bad    = w_access && (!w_legal || w_mis);
    assign w_go     = w_access && !w_bad;
    assign w_tmo    = (r_cnt == TMO_LAST);

    mem_lsu_load_ext u_load_ext (
        .i_rdata  (dram_rdata_i),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_result (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != IDLE && w_next != r_state)
                r_cnt <= '0;
            else if (r_state != IDLE)
                r_cnt <= r_cnt + 16'd1;
            if (r_state == IDLE && w_go) begin
                r_off   <= addr_mem_i[1:0];
                r_f3    <= funct3_mem_i;
                r_we    <= mem_we_i;
                r_be    <= lsu_be(funct3_mem_i, addr_mem_i[1:0]);
                r_wdata <= lsu_wdata(funct3_mem_i, rs2_mem_i);
                r_addr  <= {addr_mem_i[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        dram_req_o   = 1'b0;
        dram_we_o    = r_we;
        dram_addr_o  = r_addr;
        dram_be_o    = r_be;
        dram_wdata_o = r_wdata;
        lsu_stall_o  = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        wd_mem_o     = wd_mem_i;

        case (r_state)
            IDLE: begin
                if (w_bad) begin
                    misalign_o = 1'b1;
                end else if (w_go) begin
                    dram_req_o   = 1'b1;
                    dram_we_o    = mem_we_i;
                    dram_addr_o  = {addr_mem_i[31:2], 2'b00};
                    dram_be_o    = lsu_be(funct3_mem_i, addr_mem_i[1:0]);
                    dram_wdata_o = lsu_wdata(funct3_mem_i, rs2_mem_i);
                    if (!dram_gnt_i) begin
                        w_next      = REQ;
                        lsu_stall_o = 1'b1;
                    end else if (!mem_we_i) begin
                        w_next      = WAIT;
                        lsu_stall_o = 1'b1;
                    end
                end
            end
            REQ: begin
                dram_req_o = 1'b1;
                if (dram_gnt_i) begin
                    w_next      = r_we ? IDLE : WAIT;
                    lsu_stall_o = !r_we;
                end else if (w_tmo) begin
                    dram_req_o = 1'b0;
                    bus_err_o  = 1'b1;
                    wd_mem_o   = '0;
                    w_next     = IDLE;
                end else begin
                    lsu_stall_o = 1'b1;
                end
            end
            WAIT: begin
                if (dram_rvalid_i) begin
                    wd_mem_o = w_ext;
                    w_next   = IDLE;
                end else if (w_tmo) begin
                    bus_err_o = 1'b1;
                    wd_mem_o  = '0;
                    w_next    = IDLE;
                end else begin
                    lsu_stall_o = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads with wait states, extension, misalignment,
// timeout and reset during an outstanding load.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_mem_i, mem_re_i, mem_we_i;
    logic [2:0]  funct3_mem_i;
    logic [31:0] addr_mem_i, rs2_mem_i, wd_mem_i;
    logic [31:0] wd_mem_o;
    logic        lsu_stall_o, misalign_o, bus_err_o;
    logic        dram_req_o, dram_we_o;
    logic [31:0] dram_addr_o;
    logic [3:0]  dram_be_o;
    logic [31:0] dram_wdata_o;
    logic        dram_gnt_i, dram_rvalid_i;
    logic [31:0] dram_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid_mem_i (instr_valid_mem_i),
        .mem_re_i          (mem_re_i),
        .mem_we_i          (mem_we_i),
        .funct3_mem_i      (funct3_mem_i),
        .addr_mem_i        (addr_mem_i),
        .rs2_mem_i         (rs2_mem_i),
        .wd_mem_i          (wd_mem_i),
        .wd_mem_o          (wd_mem_o),
        .lsu_stall_o       (lsu_stall_o),
        .misalign_o        (misalign_o),
        .bus_err_o         (bus_err_o),
        .dram_req_o        (dram_req_o),
        .dram_we_o         (dram_we_o),
        .dram_addr_o       (dram_addr_o),
        .dram_be_o         (dram_be_o),
        .dram_wdata_o      (dram_wdata_o),
        .dram_gnt_i        (dram_gnt_i),
        .dram_rvalid_i     (dram_rvalid_i),
        .dram_rdata_i      (dram_rdata_i)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs settle 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid_mem_i = 1'b0;
        mem_re_i          = 1'b0;
        mem_we_i          = 1'b0;
        funct3_mem_i      = 3'b000;
        addr_mem_i        = 32'h0;
        rs2_mem_i         = 32'h0;
        dram_gnt_i        = 1'b0;
        dram_rvalid_i     = 1'b0;
        dram_rdata_i      = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic gnt);
        instr_valid_mem_i = 1'b1;
        mem_re_i          = !we;
        mem_we_i          = we;
        funct3_mem_i      = f3;
        addr_mem_i        = addr;
        rs2_mem_i         = rs2;
        dram_gnt_i        = gnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        wd_mem_i = 32'h0000_1234;
        step(); step();
        n_checks++; if (dram_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %0b want 0", dram_req_o); end
        n_checks++; if (lsu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %0b want 0", lsu_stall_o); end
        n_checks++; if ({misalign_o, bus_err_o} !== 2'b00) begin n_errors++; $display("FAIL rst_pulses: got %b want 00", {misalign_o, bus_err_o}); end
        n_checks++; if (wd_mem_o !== 32'h0000_1234) begin n_errors++; $display("FAIL rst_wd: got %h want 00001234", wd_mem_o); end
        n_checks++; if ({dram_addr_o, dram_be_o, dram_wdata_o} !== 68'h0) begin n_errors++; $display("FAIL rst_fields: addr %h be %b wdata %h want 0", dram_addr_o, dram_be_o, dram_wdata_o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_zero_wait();
        drive(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
        #1;
        n_checks++; if ({dram_req_o, dram_we_o} !== 2'b11) begin n_errors++; $display("FAIL sw_req_we: got %b want 11", {dram_req_o, dram_we_o}); end
        n_checks++; if (dram_be_o !== 4'b1111) begin n_errors++; $display("FAIL sw_be: got %b want 1111", dram_be_o); end
        n_checks++; if (dram_addr_o !== 32'h0000_0100) begin n_errors++; $display("FAIL sw_addr: got %h want 00000100", dram_addr_o); end
        n_checks++; if (dram_wdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sw_wdata: got %h want deadbeef", dram_wdata_o); end
        n_checks++; if (lsu_stall_o !== 1'b0) begin n_errors++; $display("FAIL sw_stall: got %0b want 0", lsu_stall_o); end
        step();
        drive(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1'b1);
        #1;
        n_checks++; if (dram_be_o !== 4'b1000) begin n_errors++; $display("FAIL sb_be: got %b want 1000", dram_be_o); end
        n_checks++; if (dram_wdata_o !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", dram_wdata_o); end
        n_checks++; if (dram_addr_o !== 32'h0000_0100) begin n_errors++; $display("FAIL sb_addr: got %h want 00000100", dram_addr_o); end
        n_checks++; if ({dram_req_o, lsu_stall_o} !== 2'b10) begin n_errors++; $display("FAIL sb_req_stall: got %b want 10", {dram_req_o, lsu_stall_o}); end
        step();
        drive(1'b1, 3'b001, 32'h0000_0106, 32'h1234_BEEF, 1'b1);
        #1;
        n_checks++; if (dram_be_o !== 4'b1100) begin n_errors++; $display("FAIL sh_be: got %b want 1100", dram_be_o); end
        n_checks++; if (dram_wdata_o !== 32'hBEEF_BEEF) begin n_errors++; $display("FAIL sh_wdata: got %h want beefbeef", dram_wdata_o); end
        step();
        idle_inputs();
        #1;
        n_checks++; if ({dram_req_o, lsu_stall_o} !== 2'b00) begin n_errors++; $display("FAIL st_back_idle: got %b want 00", {dram_req_o, lsu_stall_o}); end
    endtask

    task automatic test_store_delayed_gnt();
        int stalls = 0;
        drive(1'b1, 3'b010, 32'h0000_0500, 32'h0BAD_F00D, 1'b0);
        #1;
        if (lsu_stall_o) stalls++;
        step();
        n_checks++; if ({dram_req_o, dram_we_o, dram_wdata_o} !== {2'b11, 32'h0BAD_F00D}) begin n_errors++; $display("FAIL swreq_hold: req %0b we %0b wdata %h want 1 1 0badf00d", dram_req_o, dram_we_o, dram_wdata_o); end
        dram_gnt_i = 1'b1;
        #1;
        n_checks++; if (lsu_stall_o !== 1'b0) begin n_errors++; $display("FAIL swreq_done_stall: got %0b want 0", lsu_stall_o); end
        n_checks++; if (stalls !== 1) begin n_errors++; $display("FAIL swreq_stalls: got %0d want 1", stalls); end
        step();
        idle_inputs();
        #1;
        n_checks++; if (dram_req_o !== 1'b0) begin n_errors++; $display("FAIL swreq_idle: got %0b want 0", dram_req_o); end
    endtask

    task automatic test_lb_wait_states();
        int stalls = 0;
        wd_mem_i = 32'h1111_1111;
        drive(1'b0, 3'b000, 32'h0000_0202, 32'h0, 1'b0);
        #1;
        n_checks++; if ({dram_req_o, dram_we_o, dram_be_o} !== 6'b10_0100) begin n_errors++; $display("FAIL lb_req: got %b want 100100", {dram_req_o, dram_we_o, dram_be_o}); end
        n_checks++; if (dram_addr_o !== 32'h0000_0200) begin n_errors++; $display("FAIL lb_addr: got %h want 00000200", dram_addr_o); end
        for (int c = 1; c <= 6; c++) begin
            dram_gnt_i    = (c == 3);
            dram_rvalid_i = (c == 6);
            dram_rdata_i  = (c == 6) ? 32'h0080_FF00 : 32'hFFFF_FFFF;
            #1;
            if (lsu_stall_o) stalls++;
            if (c == 4) begin
                n_checks++; if (dram_req_o !== 1'b0) begin n_errors++; $display("FAIL lb_wait_req: got %0b want 0", dram_req_o); end
            end
            if (c == 6) begin
                n_checks++; if (wd_mem_o !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_wd: got %h want ffffff80", wd_mem_o); end
                n_checks++; if (lsu_stall_o !== 1'b0) begin n_errors++; $display("FAIL lb_done_stall: got %0b want 0", lsu_stall_o); end
            end
            step();
        end
        n_checks++; if (stalls !== 5) begin n_errors++; $display("FAIL lb_stalls: got %0d want 5", stalls); end
        idle_inputs();
        #1;
        n_checks++; if ({dram_req_o, lsu_stall_o, wd_mem_o} !== {2'b00, 32'h1111_1111}) begin n_errors++; $display("FAIL lb_idle: req %0b stall %0b wd %h", dram_req_o, lsu_stall_o, wd_mem_o); end
    endtask

    // One-wait load with immediate grant; checks data returned on the next cycle
    task automatic load_once(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        drive(1'b0, f3, addr, 32'h0, 1'b1);
        #1;
        n_checks++; if (lsu_stall_o !== 1'b1) begin n_errors++; $display("FAIL %s_stall: got %0b want 1", name, lsu_stall_o); end
        step();
        dram_gnt_i    = 1'b0;
        dram_rvalid_i = 1'b1;
        dram_rdata_i  = rdata;
        #1;
        n_checks++; if (wd_mem_o !== exp) begin n_errors++; $display("FAIL %s_wd: got %h want %h", name, wd_mem_o, exp); end
        step();
        idle_inputs();
    endtask

    task automatic test_load_ext();
        drive(1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b1);
        #1;
        n_checks++; if (dram_be_o !== 4'b1100) begin n_errors++; $display("FAIL lhu_be: got %b want 1100", dram_be_o); end
        idle_inputs();
        load_once("lhu", 3'b101, 32'h0000_0202, 32'h8001_1234, 32'h0000_8001);
        load_once("lh",  3'b001, 32'h0000_0202, 32'h8001_1234, 32'hFFFF_8001);
        load_once("lh0", 3'b001, 32'h0000_0200, 32'h8001_9234, 32'hFFFF_9234);
        load_once("lbu", 3'b100, 32'h0000_0201, 32'h0080_FF00, 32'h0000_00FF);
        load_once("lb3", 3'b000, 32'h0000_0203, 32'h7F00_0000, 32'h0000_007F);
        load_once("lw",  3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic test_misalign();
        wd_mem_i = 32'hCAFE_F00D;
        drive(1'b0, 3'b010, 32'h0000_0301, 32'h0, 1'b1);
        #1;
        n_checks++; if ({misalign_o, dram_req_o, lsu_stall_o} !== 3'b100) begin n_errors++; $display("FAIL lw_mis: got %b want 100", {misalign_o, dram_req_o, lsu_stall_o}); end
        n_checks++; if (wd_mem_o !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL lw_mis_wd: got %h want cafef00d", wd_mem_o); end
        step();
        drive(1'b1, 3'b001, 32'h0000_0101, 32'h0, 1'b1);
        #1;
        n_checks++; if ({misalign_o, dram_req_o} !== 2'b10) begin n_errors++; $display("FAIL sh_mis: got %b want 10", {misalign_o, dram_req_o}); end
        step();
        drive(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1);
        #1;
        n_checks++; if ({misalign_o, dram_req_o} !== 2'b10) begin n_errors++; $display("FAIL ill_f3: got %b want 10", {misalign_o, dram_req_o}); end
        step();
        drive(1'b1, 3'b100, 32'h0000_0100, 32'h0, 1'b1);
        #1;
        n_checks++; if ({misalign_o, dram_req_o} !== 2'b10) begin n_errors++; $display("FAIL ill_store: got %b want 10", {misalign_o, dram_req_o}); end
        step();
        idle_inputs();
        #1;
        n_checks++; if ({misalign_o, lsu_stall_o} !== 2'b00) begin n_errors++; $display("FAIL mis_clear: got %b want 00", {misalign_o, lsu_stall_o}); end
    endtask

    task automatic test_timeout();
        int stalls = 0;
        bit seen = 0;
        wd_mem_i = 32'h5555_5555;
        drive(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b0);
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (bus_err_o) begin
                seen = 1;
                n_checks++; if ({lsu_stall_o, dram_req_o, wd_mem_o} !== 34'h0) begin n_errors++; $display("FAIL tmo_outputs: stall %0b req %0b wd %h want 0", lsu_stall_o, dram_req_o, wd_mem_o); end
            end else if (lsu_stall_o) begin
                stalls++;
            end
            step();
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL tmo_seen: got no bus_err_o within 10 cycles, want a pulse"); end
        n_checks++; if (stalls !== 4) begin n_errors++; $display("FAIL tmo_stalls: got %0d want 4", stalls); end
        idle_inputs();
        #1;
        n_checks++; if ({bus_err_o, lsu_stall_o, dram_req_o} !== 3'b000) begin n_errors++; $display("FAIL tmo_idle: got %b want 000", {bus_err_o, lsu_stall_o, dram_req_o}); end
    endtask

    task automatic test_reset_in_wait();
        wd_mem_i = 32'h0000_0055;
        drive(1'b0, 3'b010, 32'h0000_0600, 32'h0, 1'b1);
        step();
        idle_inputs();
        #1;
        n_checks++; if (lsu_stall_o !== 1'b1) begin n_errors++; $display("FAIL rw_wait_stall: got %0b want 1", lsu_stall_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (lsu_stall_o !== 1'b0) begin n_errors++; $display("FAIL rw_async_stall: got %0b want 0", lsu_stall_o); end
        step();
        rst_n = 1'b1;
        dram_rvalid_i = 1'b1;
        dram_rdata_i  = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (wd_mem_o !== 32'h0000_0055) begin n_errors++; $display("FAIL rw_wd: got %h want 00000055", wd_mem_o); end
        n_checks++; if ({dram_req_o, lsu_stall_o, bus_err_o} !== 3'b000) begin n_errors++; $display("FAIL rw_ctrl: got %b want 000", {dram_req_o, lsu_stall_o, bus_err_o}); end
        n_checks++; if ({dram_addr_o, dram_be_o, dram_wdata_o} !== 68'h0) begin n_errors++; $display("FAIL rw_fields: addr %h be %b wdata %h want 0", dram_addr_o, dram_be_o, dram_wdata_o); end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_store_zero_wait();
        test_store_delayed_gnt();
        test_lb_wait_states();
        test_load_ext();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
